// File: rtl/vga_pkg.sv
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared VGA constants, colours and the frame-update FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int unsigned X_MIN  = 144;
    localparam int unsigned X_MAX  = 783;
    localparam int unsigned Y_MIN  = 35;
    localparam int unsigned Y_MAX  = 514;
    localparam int unsigned V_TICK = 515;

    localparam logic [11:0] GREEN = 12'h0F0;
    localparam logic [11:0] WHITE = 12'hFFF;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        CALC  = 2'd1,
        APPLY = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/frame_tick_gen.sv
// ============================================================================
//  Module      : frame_tick_gen
//  Description : One-clk pulse when the raster reaches (H_PIX, V_LINE).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_tick_gen
    import vga_pkg::*;
#(
    parameter int unsigned V_LINE = V_TICK,
    parameter int unsigned H_PIX  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] hCount,
    input  logic [9:0] vCount,
    output logic       frame_tick
);

    logic hit_r;
    logic hit_q;

    // The pixel counters hold each value for several clocks, so only the
    // rising edge of the compare is forwarded.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_r <= 1'b0;
            hit_q <= 1'b0;
        end else begin
            hit_r <= (vCount == 10'(V_LINE)) && (hCount == 10'(H_PIX));
            hit_q <= hit_r;
        end
    end

    assign frame_tick = hit_r & ~hit_q;

endmodule

`default_nettype wire

// File: rtl/block_motion_controller.sv
// ============================================================================
//  Module      : block_motion_controller
//  Description : Per-frame block position update with speed ramp, edge clamp
//                and recenter. Optional AUTO_BOUNCE_EN adds idle auto-bounce.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module block_motion_controller
    import vga_pkg::*;
#(
    parameter int unsigned X_RESET  = 450,
    parameter int unsigned Y_RESET  = 250,
    parameter int unsigned HALF_W   = 150,
    parameter int unsigned HALF_H   = 90,
    parameter int unsigned STEP_MIN = 1,
    parameter int unsigned STEP_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] hCount,
    input  logic [9:0] vCount,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_center,
    output logic [9:0] xpos,
    output logic [9:0] ypos,
    output logic       frame_tick,
    output logic       moving
);

    localparam logic signed [11:0] X_LO = 12'(X_MIN + HALF_W);
    localparam logic signed [11:0] X_HI = 12'(X_MAX - HALF_W);
    localparam logic signed [11:0] Y_LO = 12'(Y_MIN + HALF_H);
    localparam logic signed [11:0] Y_HI = 12'(Y_MAX - HALF_H);

    function automatic logic [9:0] clamp(input logic signed [11:0] v,
                                         input logic signed [11:0] lo,
                                         input logic signed [11:0] hi);
        logic signed [11:0] r;
        if (v < lo)
            r = lo;
        else if (v > hi)
            r = hi;
        else
            r = v;
        return 10'(r);
    endfunction

    state_t            state;
    logic              req_up, req_down, req_left, req_right, req_center;
    logic              cur_up, cur_down, cur_left, cur_right, cur_center;
    logic signed [1:0] cdx, cdy;
    logic signed [1:0] dx, dy;
    logic              center_q;
    logic [3:0]        speed;
    logic              moved_last;
    logic signed [11:0] nx, ny;
    logic [9:0]        next_x, next_y;
    logic              changed;

`ifdef AUTO_BOUNCE_EN
    localparam int unsigned IDLE_FRAMES = 120;
    logic [6:0]        idle_cnt;
    logic              bounce;
    logic signed [1:0] bdx, bdy;
    logic              any_req;
    assign any_req = cur_up | cur_down | cur_left | cur_right | cur_center;
`endif

    frame_tick_gen #(
        .V_LINE (V_TICK),
        .H_PIX  (0)
    ) u_tick (
        .clk        (clk),
        .rst        (rst),
        .hCount     (hCount),
        .vCount     (vCount),
        .frame_tick (frame_tick)
    );

    assign cur_up     = req_up     | btn_up;
    assign cur_down   = req_down   | btn_down;
    assign cur_left   = req_left   | btn_left;
    assign cur_right  = req_right  | btn_right;
    assign cur_center = req_center | btn_center;

    // Opposite buttons on one axis cancel out.
    assign cdx = (cur_right & ~cur_left) ? 2'sd1 : (cur_left & ~cur_right) ? -2'sd1 : 2'sd0;
    assign cdy = (cur_down  & ~cur_up)   ? 2'sd1 : (cur_up   & ~cur_down)  ? -2'sd1 : 2'sd0;

    always_comb begin
        nx = $signed({2'b00, xpos});
        ny = $signed({2'b00, ypos});
        if (dx == 2'sd1)
            nx = nx + $signed({8'b0, speed});
        else if (dx == -2'sd1)
            nx = nx - $signed({8'b0, speed});
        if (dy == 2'sd1)
            ny = ny + $signed({8'b0, speed});
        else if (dy == -2'sd1)
            ny = ny - $signed({8'b0, speed});

        next_x = xpos;
        next_y = ypos;
        if (center_q) begin
            next_x = 10'(X_RESET);
            next_y = 10'(Y_RESET);
        end else if (dx != 2'sd0 || dy != 2'sd0) begin
            next_x = clamp(nx, X_LO, X_HI);
            next_y = clamp(ny, Y_LO, Y_HI);
        end
        changed = (next_x != xpos) || (next_y != ypos);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= WAIT;
            xpos       <= 10'(X_RESET);
            ypos       <= 10'(Y_RESET);
            moving     <= 1'b0;
            speed      <= 4'(STEP_MIN);
            moved_last <= 1'b0;
            dx         <= 2'sd0;
            dy         <= 2'sd0;
            center_q   <= 1'b0;
            req_up     <= 1'b0;
            req_down   <= 1'b0;
            req_left   <= 1'b0;
            req_right  <= 1'b0;
            req_center <= 1'b0;
`ifdef AUTO_BOUNCE_EN
            idle_cnt   <= 7'd0;
            bounce     <= 1'b0;
            bdx        <= 2'sd1;
            bdy        <= 2'sd1;
`endif
        end else begin
            case (state)
                WAIT: begin
                    req_up     <= cur_up;
                    req_down   <= cur_down;
                    req_left   <= cur_left;
                    req_right  <= cur_right;
                    req_center <= cur_center;
                    if (frame_tick)
                        state <= CALC;
                end
                CALC: begin
                    req_up     <= cur_up;
                    req_down   <= cur_down;
                    req_left   <= cur_left;
                    req_right  <= cur_right;
                    req_center <= cur_center;
                    center_q   <= cur_center;
                    dx         <= cdx;
                    dy         <= cdy;
                    if (cur_center || (cdx == 2'sd0 && cdy == 2'sd0))
                        speed <= 4'(STEP_MIN);
                    else if (moved_last)
                        speed <= (speed >= 4'(STEP_MAX)) ? 4'(STEP_MAX) : speed + 4'd1;
                    else
                        speed <= 4'(STEP_MIN);
`ifdef AUTO_BOUNCE_EN
                    if (any_req) begin
                        bounce   <= 1'b0;
                        idle_cnt <= 7'd0;
                    end else if (bounce) begin
                        dx <= bdx;
                        dy <= bdy;
                    end else if (idle_cnt == 7'(IDLE_FRAMES - 1)) begin
                        bounce   <= 1'b1;
                        bdx      <= 2'sd1;
                        bdy      <= 2'sd1;
                        idle_cnt <= 7'd0;
                    end else begin
                        idle_cnt <= idle_cnt + 7'd1;
                    end
`else
                    // Without auto-bounce an idle frame leaves the block in place.
`endif
                    state <= APPLY;
                end
                APPLY: begin
                    // A press landing on this cycle survives into the next frame.
                    req_up     <= btn_up;
                    req_down   <= btn_down;
                    req_left   <= btn_left;
                    req_right  <= btn_right;
                    req_center <= btn_center;
                    xpos       <= next_x;
                    ypos       <= next_y;
                    moving     <= changed;
                    moved_last <= changed & ~center_q;
`ifdef AUTO_BOUNCE_EN
                    if (bounce && !center_q) begin
                        if (dx == 2'sd1 && nx >= X_HI)
                            bdx <= -2'sd1;
                        else if (dx == -2'sd1 && nx <= X_LO)
                            bdx <= 2'sd1;
                        if (dy == 2'sd1 && ny >= Y_HI)
                            bdy <= -2'sd1;
                        else if (dy == -2'sd1 && ny <= Y_LO)
                            bdy <= 2'sd1;
                    end
`endif
                    state <= WAIT;
                end
                default: state <= WAIT;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_block_motion_controller.sv
// ============================================================================
//  Module      : tb_block_motion_controller
//  Description : Self-checking bench with a frame-level position/speed model
//                and a compressed raster driving the tick compare.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_block_motion_controller;

    localparam logic [4:0] B_R = 5'b00001;
    localparam logic [4:0] B_L = 5'b00010;
    localparam logic [4:0] B_D = 5'b00100;
    localparam logic [4:0] B_U = 5'b01000;
    localparam logic [4:0] B_C = 5'b10000;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] hCount, vCount;
    logic       btn_up, btn_down, btn_left, btn_right, btn_center;
    logic [9:0] xpos, ypos;
    logic       frame_tick, moving;

    int         checks = 0;
    int         errors = 0;

    int         mx, my, mspeed;
    bit         mmov, mprev;
    logic [4:0] held, pend;

    block_motion_controller dut (
        .clk        (clk),
        .rst        (rst),
        .hCount     (hCount),
        .vCount     (vCount),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_center (btn_center),
        .xpos       (xpos),
        .ypos       (ypos),
        .frame_tick (frame_tick),
        .moving     (moving)
    );

    always #5 clk = ~clk;

    // Compressed raster: 4 pixels per line, lines 510..524, 4 clk per pixel.
    initial begin
        int div;
        div    = 0;
        hCount = 10'd0;
        vCount = 10'd510;
        forever begin
            @(negedge clk);
            div++;
            if (div == 4) begin
                div = 0;
                if (hCount == 10'd3) begin
                    hCount = 10'd0;
                    vCount = (vCount == 10'd524) ? 10'd510 : vCount + 10'd1;
                end else begin
                    hCount = hCount + 10'd1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] b);
        btn_right  = b[0];
        btn_left   = b[1];
        btn_down   = b[2];
        btn_up     = b[3];
        btn_center = b[4];
    endtask

    task automatic set_btns(input logic [4:0] b);
        held = b;
        pend = pend | b;
        drive(b);
    endtask

    function automatic int lim(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    task automatic model_reset();
        mx = 450; my = 250; mspeed = 1; mmov = 0; mprev = 0;
    endtask

    // One frame update computed from the button rules.
    task automatic model_update(input logic [4:0] r);
        int dx, dy, nx, ny;
        dx = int'(r[0]) - int'(r[1]);
        dy = int'(r[2]) - int'(r[3]);
        if (r[4]) begin
            nx = 450; ny = 250; mspeed = 1;
            mmov = (nx != mx) || (ny != my);
            mprev = 0;
        end else if (dx == 0 && dy == 0) begin
            nx = mx; ny = my; mspeed = 1; mmov = 0; mprev = 0;
        end else begin
            mspeed = mprev ? ((mspeed + 1 > 8) ? 8 : mspeed + 1) : 1;
            nx = lim(mx + dx * mspeed, 294, 633);
            ny = lim(my + dy * mspeed, 125, 424);
            mmov = (nx != mx) || (ny != my);
            mprev = mmov;
        end
        mx = nx;
        my = ny;
    endtask

    task automatic wait_tick(output bit found);
        int n;
        n = 0;
        found = 0;
        while (n < 600 && !found) begin
            @(negedge clk);
            if (frame_tick === 1'b1) found = 1;
            n++;
        end
        if (!found) check("tick_timeout", 16'd0, 16'd1);
    endtask

    // Optional 1-clk pulse mid-frame, then one update; 'nxt' is what is held
    // from the APPLY cycle onward (it becomes the next frame's request).
    task automatic frame(input logic [4:0] pulse, input logic [4:0] nxt);
        bit ok;
        if (pulse != 5'd0) begin
            repeat (20) @(negedge clk);
            drive(held | pulse);
            @(negedge clk);
            drive(held);
            pend = pend | pulse;
        end
        wait_tick(ok);
        if (!ok) return;
        @(negedge clk);
        check("tick_width", 16'(frame_tick), 16'd0);
        @(negedge clk);
        check("x_before_apply", 16'(xpos), 16'(mx));
        held = nxt;
        drive(nxt);
        @(negedge clk);
        model_update(pend);
        pend = nxt;
        check("xpos", 16'(xpos), 16'(mx));
        check("ypos", 16'(ypos), 16'(my));
        check("moving", 16'(moving), 16'(mmov));
    endtask

    initial begin
        bit ok;
        int n;
        logic [4:0] nb, pb;

        rst = 1'b0;
        held = 5'd0;
        pend = 5'd0;
        drive(5'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
        check("reset_x", 16'(xpos), 16'd450);
        check("reset_y", 16'(ypos), 16'd250);
        check("reset_moving", 16'(moving), 16'd0);
        check("reset_tick", 16'(frame_tick), 16'd0);

        // Exactly one tick per (compressed) frame of 240 clk.
        wait_tick(ok);
        n = 0;
        repeat (960) begin
            @(negedge clk);
            if (frame_tick === 1'b1) n++;
        end
        check("ticks_per_4_frames", 16'(n), 16'd4);
        repeat (10) @(negedge clk);

        // Held right: steps 1..8 then 8,8,8.
        set_btns(B_R);
        repeat (10) frame(5'd0, B_R);
        frame(5'd0, 5'd0);
        check("ramp_final_x", 16'(xpos), 16'd510);

        // Short press is latched for exactly one frame.
        frame(5'd0, 5'd0);
        frame(B_R, 5'd0);
        frame(5'd0, 5'd0);

        // Left+right cancel while up ramps into the top clamp.
        set_btns(B_L | B_R | B_U);
        repeat (21) frame(5'd0, B_L | B_R | B_U);
        frame(5'd0, 5'd0);
        check("top_clamp_y", 16'(ypos), 16'd125);
        check("top_clamp_moving", 16'(moving), 16'd0);

        // Right wall.
        set_btns(B_R);
        repeat (20) frame(5'd0, B_R);
        frame(5'd0, 5'd0);
        check("right_clamp_x", 16'(xpos), 16'd633);
        check("right_clamp_moving", 16'(moving), 16'd0);

        // Recenter beats down; speed restarts at the minimum afterwards.
        set_btns(B_C | B_D);
        frame(5'd0, 5'd0);
        check("recenter_x", 16'(xpos), 16'd450);
        set_btns(B_R);
        frame(5'd0, 5'd0);
        check("after_recenter_x", 16'(xpos), 16'd451);

        // Reset landing on the CALC cycle discards the pending update.
        set_btns(B_R | B_D);
        frame(5'd0, B_R | B_D);
        wait_tick(ok);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        check("calc_reset_x", 16'(xpos), 16'd450);
        check("calc_reset_y", 16'(ypos), 16'd250);
        check("calc_reset_moving", 16'(moving), 16'd0);
        repeat (5) @(negedge clk);
        check("calc_reset_no_stale_x", 16'(xpos), 16'd450);
        model_reset();
        pend = held;

        // Random button mixes against the frame model.
        repeat (40) begin
            nb = 5'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) nb[4] = 1'b1;
            pb = 5'd0;
            if ($urandom_range(0, 3) == 0) pb = 5'd1 << $urandom_range(0, 3);
            frame(pb, nb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
